// File: rtl/alarm_sequencer.sv
// alarm_sequencer: alarm controller between the hh:mm:ss counters and the song player.
// Holds the alarm setpoint, detects the alarm time and sequences ringing, snooze
// and timeout. The snooze feature is compiled in only when ALARM_SNOOZE_EN is defined;
// without it btn_snooze is ignored, SNOOZE is unreachable and snooze_left reads 0.
module alarm_sequencer #(
    parameter int RESET_HOUR     = 7,
    parameter int RESET_MIN      = 0,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       alarm_en,
    input  logic       btn_set_h,
    input  logic       btn_set_m,
    input  logic       btn_snooze,
    input  logic       btn_stop,
    output logic       play_sound,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_min,
    output logic [1:0] state,
    output logic [1:0] snooze_left
);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } state_t;

    localparam logic [4:0] HOUR_INIT = 5'(RESET_HOUR);
    localparam logic [5:0] MIN_INIT  = 6'(RESET_MIN);
    localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);

    state_t     cur_state;
    state_t     next_state;
    logic [7:0] ring_cnt;
    logic [7:0] ring_cnt_next;
    logic [4:0] hour_next;
    logic [5:0] min_next;
    logic       fired;
    logic       fired_next;
    logic       match;
    logic       edit_ok;
    logic       edit;

`ifdef ALARM_SNOOZE_EN
    localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SECONDS - 1);
    localparam logic [1:0] SNOOZE_INIT = 2'(MAX_SNOOZE);

    logic [9:0] snooze_cnt;
    logic [9:0] snooze_cnt_next;
    logic [1:0] snooze_left_r;
    logic [1:0] snooze_left_next;

    assign snooze_left = snooze_left_r;
`else
    logic unused_snooze;

    assign unused_snooze = &{1'b0, btn_snooze, SNOOZE_SECONDS[0], MAX_SNOOZE[0]};
    assign snooze_left   = 2'd0;
`endif

    assign state = cur_state;

    // Next-state, counter, setpoint and fired-flag logic; buttons beat ticks in the same cycle
    always_comb begin
        next_state    = cur_state;
        ring_cnt_next = ring_cnt;
        hour_next     = alarm_hour;
        min_next      = alarm_min;
        fired_next    = fired;
`ifdef ALARM_SNOOZE_EN
        snooze_cnt_next  = snooze_cnt;
        snooze_left_next = snooze_left_r;
`endif

        match   = (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == 6'd0);
        edit_ok = (cur_state == DISARMED) || (cur_state == ARMED);
        edit    = edit_ok && (btn_set_h || btn_set_m);

        if (edit_ok && btn_set_h) begin
            hour_next = (alarm_hour == 5'd23) ? 5'd0 : alarm_hour + 5'd1;
        end
        if (edit_ok && btn_set_m) begin
            min_next = (alarm_min == 6'd59) ? 6'd0 : alarm_min + 6'd1;
        end

        case (cur_state)
            DISARMED: begin
                if (alarm_en) begin
                    next_state = ARMED;
                end
            end
            ARMED: begin
                if (!alarm_en) begin
                    next_state = DISARMED;
                end else if (match && !fired) begin
                    next_state = RINGING;
                end
            end
            RINGING: begin
                if (!alarm_en) begin
                    next_state = DISARMED;
                end else if (btn_stop) begin
                    next_state = ARMED;
`ifdef ALARM_SNOOZE_EN
                end else if (btn_snooze) begin
                    if (snooze_left_r != 2'd0) begin
                        next_state       = SNOOZE;
                        snooze_left_next = snooze_left_r - 2'd1;
                    end else begin
                        next_state = ARMED;
                    end
`endif
                end else if (tick_1hz) begin
                    if (ring_cnt == RING_LAST) begin
                        next_state = ARMED;
                    end else begin
                        ring_cnt_next = ring_cnt + 8'd1;
                    end
                end
            end
            SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
                if (!alarm_en) begin
                    next_state = DISARMED;
                end else if (btn_stop) begin
                    next_state = ARMED;
                end else if (tick_1hz) begin
                    if (snooze_cnt == SNOOZE_LAST) begin
                        next_state = RINGING;
                    end else begin
                        snooze_cnt_next = snooze_cnt + 10'd1;
                    end
                end
`else
                next_state = DISARMED;
`endif
            end
            default: next_state = DISARMED;
        endcase

        if (next_state != cur_state) begin
            ring_cnt_next = 8'd0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_next = 10'd0;
            if ((next_state == ARMED) || (next_state == DISARMED)) begin
                snooze_left_next = SNOOZE_INIT;
            end
`endif
        end

        if ((next_state == RINGING) && (cur_state != RINGING)) begin
            fired_next = 1'b1;
        end else if (edit || (cur_min != alarm_min)) begin
            fired_next = 1'b0;
        end
    end

    // State, counters, setpoint and registered play_sound level
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state  <= DISARMED;
            play_sound <= 1'b0;
            alarm_hour <= HOUR_INIT;
            alarm_min  <= MIN_INIT;
            ring_cnt   <= 8'd0;
            fired      <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt    <= 10'd0;
            snooze_left_r <= SNOOZE_INIT;
`endif
        end else begin
            cur_state  <= next_state;
            play_sound <= (next_state == RINGING);
            alarm_hour <= hour_next;
            alarm_min  <= min_next;
            ring_cnt   <= ring_cnt_next;
            fired      <= fired_next;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt    <= snooze_cnt_next;
            snooze_left_r <= snooze_left_next;
`endif
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer: directed self-checking bench for alarm_sequencer.
// Snooze scenarios are selected by ALARM_SNOOZE_EN to match the RTL build.
module tb_alarm_sequencer;

`ifdef ALARM_SNOOZE_EN
    localparam int EXP_SL = 3;
`else
    localparam int EXP_SL = 0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic       alarm_en;
    logic       btn_set_h;
    logic       btn_set_m;
    logic       btn_snooze;
    logic       btn_stop;
    logic       play_sound;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [1:0] state;
    logic [1:0] snooze_left;

    int errors = 0;
    int checks = 0;

    alarm_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .cur_hour    (cur_hour),
        .cur_min     (cur_min),
        .cur_sec     (cur_sec),
        .alarm_en    (alarm_en),
        .btn_set_h   (btn_set_h),
        .btn_set_m   (btn_set_m),
        .btn_snooze  (btn_snooze),
        .btn_stop    (btn_stop),
        .play_sound  (play_sound),
        .alarm_hour  (alarm_hour),
        .alarm_min   (alarm_min),
        .state       (state),
        .snooze_left (snooze_left)
    );

    // 100 MHz clock
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic t, input logic sh, input logic sm, input logic sn, input logic st);
        tick_1hz   = t;
        btn_set_h  = sh;
        btn_set_m  = sm;
        btn_snooze = sn;
        btn_stop   = st;
        step();
        tick_1hz   = 1'b0;
        btn_set_h  = 1'b0;
        btn_set_m  = 1'b0;
        btn_snooze = 1'b0;
        btn_stop   = 1'b0;
    endtask

    task automatic doTicks(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    task automatic setTime(input int h, input int m, input int s);
        cur_hour = 5'(h);
        cur_min  = 6'(m);
        cur_sec  = 6'(s);
    endtask

    // Leave the alarm minute to clear fired, then hit 07:00:00 again
    task automatic ringNow();
        setTime(7, 1, 0);
        step();
        setTime(7, 0, 0);
        step();
        setTime(7, 0, 1);
    endtask

    // Directed scenario sequence
    initial begin
        reset      = 1'b1;
        alarm_en   = 1'b0;
        tick_1hz   = 1'b0;
        btn_set_h  = 1'b0;
        btn_set_m  = 1'b0;
        btn_snooze = 1'b0;
        btn_stop   = 1'b0;
        setTime(0, 0, 0);
        step();
        step();
        checkOutput("reset_state", state, 0);
        checkOutput("reset_play", play_sound, 0);
        checkOutput("reset_hour", alarm_hour, 7);
        checkOutput("reset_min", alarm_min, 0);
        checkOutput("reset_snooze_left", snooze_left, EXP_SL);

        reset    = 1'b0;
        alarm_en = 1'b1;
        step();
        checkOutput("arm", state, 1);

        setTime(6, 59, 59);
        step();
        checkOutput("pre_match_state", state, 1);
        checkOutput("pre_match_play", play_sound, 0);
        setTime(7, 0, 0);
        step();
        checkOutput("match_state", state, 2);
        checkOutput("match_play", play_sound, 1);
        setTime(7, 0, 1);
        doTicks(59);
        checkOutput("ring_59_ticks", state, 2);
        doTicks(1);
        checkOutput("auto_stop_state", state, 1);
        checkOutput("auto_stop_play", play_sound, 0);

        setTime(7, 0, 0);
        step();
        checkOutput("no_retrigger_auto", state, 1);

        ringNow();
        checkOutput("next_day_ring", state, 2);
        doTicks(5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("stop_state", state, 1);
        checkOutput("stop_play", play_sound, 0);
        setTime(7, 0, 0);
        step();
        step();
        checkOutput("no_retrigger_stop", state, 1);

        ringNow();
        checkOutput("ring_for_tick59", state, 2);
        doTicks(59);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("stop_with_tick", state, 1);

        ringNow();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("set_in_ring_state", state, 2);
        checkOutput("set_in_ring_hour", alarm_hour, 7);
        checkOutput("set_in_ring_min", alarm_min, 0);

`ifdef ALARM_SNOOZE_EN
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput("snooze_state", state, 3);
            checkOutput("snooze_left_dec", snooze_left, 2 - k);
            checkOutput("snooze_play", play_sound, 0);
            doTicks(299);
            checkOutput("snooze_299", state, 3);
            doTicks(1);
            checkOutput("rering_state", state, 2);
            checkOutput("rering_play", play_sound, 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("snooze_as_stop", state, 1);
        checkOutput("snooze_reload", snooze_left, 3);

        ringNow();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("snooze_again", state, 3);
        alarm_en = 1'b0;
        step();
        checkOutput("disarm_in_snooze", state, 0);
        checkOutput("disarm_in_snooze_play", play_sound, 0);
        alarm_en = 1'b1;
        step();
        checkOutput("rearm", state, 1);
`else
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("snooze_ignored_state", state, 2);
        checkOutput("snooze_ignored_left", snooze_left, 0);
        checkOutput("snooze_ignored_play", play_sound, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("stop_after_snooze", state, 1);
`endif

        ringNow();
        checkOutput("ring_before_disarm", state, 2);
        alarm_en = 1'b0;
        step();
        checkOutput("disarm_state", state, 0);
        checkOutput("disarm_play", play_sound, 0);
        setTime(7, 1, 0);
        step();
        setTime(7, 0, 0);
        step();
        checkOutput("disarmed_no_ring", state, 0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 59; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("set_hour_23", alarm_hour, 23);
        checkOutput("set_min_59", alarm_min, 59);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("wrap_hour", alarm_hour, 0);
        checkOutput("wrap_min", alarm_min, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("hour_plus_one", alarm_hour, 1);

        alarm_en = 1'b1;
        step();
        setTime(1, 0, 0);
        step();
        checkOutput("ring_0100", state, 2);
        reset = 1'b1;
        step();
        checkOutput("midreset_state", state, 0);
        checkOutput("midreset_play", play_sound, 0);
        checkOutput("midreset_hour", alarm_hour, 7);
        checkOutput("midreset_min", alarm_min, 0);
        checkOutput("midreset_snooze_left", snooze_left, EXP_SL);
        reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
